// File: rtl/transpose_buffer_pkg.sv
// rtl/transpose_buffer_pkg.sv - shared sizes and schedule constants for the 2-D transform transpose stage
package transpose_buffer_pkg;

  // Default block geometry: 32x32 coefficients, 16 bits each
  localparam int N_DEF     = 32;
  localparam int WIDTH_DEF = 16;

  // Row and column pointers address one of N_DEF rows/columns
  localparam int PTR_W = $clog2(N_DEF);

  // Pipeline schedule shared with the control FSM: one load pass, then one unload pass
  localparam int LOAD_CYCLES   = 32;
  localparam int UNLOAD_CYCLES = 32;

endpackage

// File: rtl/transpose_buffer_counter.sv
// rtl/transpose_buffer_counter.sv - wrapping up-counter with terminal-count flag
module counter #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] n    = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  // last marks the terminal value so the caller can act on the wrapping step
  assign last = (count == n);

  // Advance on enable, wrapping to zero after the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/transpose_buffer.sv
// rtl/transpose_buffer.sv - row-in / column-out transpose memory between the two 1-D DCT passes
module transpose_buffer
  import transpose_buffer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_trans,
  input  logic               unload_trans,
  input  logic [N*WIDTH-1:0] din,
  output logic [N*WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               full,
  output logic               err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] mem [N][N];

  logic [PW-1:0] wr_row;
  logic [PW-1:0] rd_col;
  logic          wr_last;
  logic          rd_last;
  logic          do_load;
  logic          do_unload;
  logic          violation;

  // full selects which strobe may act; the other one in the same cycle is a violation
  assign do_load   = load_trans & ~full;
  assign do_unload = unload_trans & full;
  assign violation = (load_trans & full) | (unload_trans & ~full);

  counter #(
    .WIDTH (PW),
    .n     (PW'(N - 1))
  ) u_wr_row (
    .clk   (clk),
    .rst   (rst),
    .en    (do_load),
    .count (wr_row),
    .last  (wr_last)
  );

  counter #(
    .WIDTH (PW),
    .n     (PW'(N - 1))
  ) u_rd_col (
    .clk   (clk),
    .rst   (rst),
    .en    (do_unload),
    .count (rd_col),
    .last  (rd_last)
  );

  // Row write into the array; contents are data-only and deliberately not reset
  always_ff @(posedge clk) begin
    if (do_load) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_row][k] <= din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Column read: gather element rd_col of every row into the registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (do_unload) begin
      for (int r = 0; r < N; r++) begin
        dout[r*WIDTH +: WIDTH] <= mem[r][rd_col];
      end
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

  // full sets on the last row write and clears on the last column read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (do_load && wr_last) begin
      full <= 1'b1;
    end else if (do_unload && rd_last) begin
      full <= 1'b0;
    end
  end

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (violation) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/transpose_buffer.md
# transpose_buffer

Row-in / column-out transpose memory between the first (row) 1-D DCT and the second (column) 1-D DCT of the 2-D HEVC transform. It writes one N-coefficient row per cycle while `load_trans` is high, then emits one N-coefficient column per cycle while `unload_trans` is high. Both strobes come from the pipeline control FSM: 32 load cycles followed by 32 unload cycles per block.

## Interface
- `N`, 32: block dimension; rows per load and columns per unload.
- `WIDTH`, 16: bits per coefficient, two's complement, passed through unmodified.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `load_trans`  in  1  write `din` as the next row this cycle.
- `unload_trans`  in  1  read the next column this cycle.
- `din`  in  N*WIDTH  row; coefficient k occupies bits [k*WIDTH +: WIDTH].
- `dout`  out  N*WIDTH  column; element r is row r of the current column, same packing.
- `dout_valid`  out  1  `dout` holds a valid column.
- `full`  out  1  all N rows written and not yet fully read.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Storage is an N×N array of WIDTH-bit registers. It is not reset; contents after reset are don't-care.
- Write pointer `wr_row` and read pointer `rd_col` are each log2(N) bits.
- **Load** (`load_trans`=1, `full`=0):
  - mem[`wr_row`][k] ← `din`[k] for all k.
  - `wr_row` increments.
  - On the write with `wr_row`=N-1, `wr_row` wraps to 0 and `full` sets.
- **Unload** (`unload_trans`=1, `full`=1):
  - `dout`[r] ← mem[r][`rd_col`] for all r, and `dout_valid` ← 1.
  - `rd_col` increments.
  - On `rd_col`=N-1, `rd_col` wraps to 0 and `full` clears in the same edge.
- **Idle** (neither strobe): pointers hold, `dout` holds its last value, `dout_valid` ← 0.
- **Gaps:** a deassertion mid-load or mid-unload holds the pointer. The next strobe resumes at the held row or column; no restart.
- **Boundary and violation cases:**
  - `load_trans` while `full`=1: write ignored, `err` sets.
  - `unload_trans` while `full`=0: no read, `dout_valid`=0, `err` sets.
  - Both strobes in the same cycle: unload wins if `full`=1, load wins if `full`=0. The losing strobe is treated as a violation (`err` sets).
- `err` clears only on `rst`.
- Reset mid-operation: pointers, `full`, `dout_valid` and `err` return to reset values immediately. A partial block is discarded.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `full`=0, `err`=0, `wr_row`=0, `rd_col`=0.
- Write latency: a row sampled at edge t is readable at edge t+1. `full` is visible in the cycle after the N-th write edge.
- Read latency: 1 cycle. An `unload_trans` sampled at edge t gives `dout`/`dout_valid` valid after edge t.
- Output spacing: back-to-back unloads give one column per cycle. N unload cycles produce N consecutive valid cycles, columns 0..N-1 in order.
- `full` deasserts after the edge that reads column N-1.
  - With the control FSM's schedule (32 load cycles, then 32 unload cycles), `err` never sets.
  - Load may restart on the cycle after that edge.
- `dout` is fully registered; no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the `N` and `WIDTH` defaults;
  - the row/column pointer width, log2(N);
  - the schedule constants used by both this block and the control FSM: the load-cycle count (32) and the unload-cycle count (32).
- `wr_row` and `rd_col` each use the existing `counter` sub-module (`WIDTH` parameter, `n` = N-1 terminal, `last` output), instanced twice.
  - Its `last` output drives the set and clear of `full`.
- Column-select mux and array stay inline. No further sub-modules.

## Test plan
- **Reset:** reset, then 32 loads with `din`[k] = 32·row + k, then 32 unloads. Expect column c element r = 32·r + c. `dout_valid` high for exactly 32 cycles, `full` 1→0 after the last read, `err`=0.
- **Gapped load/unload:** load 10 rows, idle 5 cycles, load 22 rows, unload 16, idle 3, unload 16. Expect the same data as the reset scenario and no `err`.
- **Overrun:** 33rd `load_trans` while `full`=1. Expect memory unchanged (verify by unload), `err`=1 held until `rst`.
- **Underrun:** `unload_trans` straight after reset. Expect `dout_valid`=0, `dout`=0, `err`=1.
- **Simultaneous strobes:** both strobes with `full`=1 at column 5. Expect column 5 output, `rd_col` advances, `err`=1.
- **Async reset:** assert `rst` mid-unload at column 12, between clock edges. Expect outputs cleared immediately, `full`=0. A fresh 32-load/32-unload pass afterwards returns new data with column 0 first.
